clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog.sv | 91 +++++++++
 tb/tb_clk_div_prog.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable clock divider with a valid/ready setting handshake.
// New ratios take effect only at a period boundary, so no output period is ever cut short.
module clk_div_prog #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEFAULT_M = 2
) (
  input  logic             reset,
  input  logic             clk,
  input  logic             en,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_m,
  input  logic             div_mode,
  output logic             div_ready,
  output logic             div_err,
  output logic             out_clk,
  output logic             tick,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] m_act, m_pend, m_nxt, cnt_nxt;
  logic             mode_act, mode_pend, mode_nxt, pend_v;
  logic             out_clk_r, tick_r, div_err_r;
  logic             wrap, apply, accept, tick_nxt, out_nxt;
  logic [WIDTH:0]   half_nxt;

  always_comb begin
    wrap     = 1'b0;
    apply    = 1'b0;
    accept   = 1'b0;
    m_nxt    = m_act;
    mode_nxt = mode_act;
    cnt_nxt  = '0;
    half_nxt = '0;
    tick_nxt = 1'b0;
    out_nxt  = 1'b0;

    // Compared in WIDTH+1 bits so m_act at full scale cannot overflow.
    wrap   = en & ((m_act == WIDTH'(1)) |
                   (({1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1}) == {1'b0, m_act}));
    accept = div_valid & ~pend_v;
    apply  = pend_v & (~en | wrap);

    if (apply) begin
      m_nxt    = m_pend;
      mode_nxt = mode_pend;
    end

    cnt_nxt = (~en | wrap) ? '0 : cnt + WIDTH'(1);

    // Outputs are derived from the next count and the setting that will own it,
    // keeping them phase-aligned with cnt across a setting change.
    half_nxt = ({1'b0, m_nxt} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    tick_nxt = en & (cnt_nxt == '0);
    out_nxt  = en & (mode_nxt ? ({1'b0, cnt_nxt} < half_nxt) : (cnt_nxt == '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act     <= WIDTH'(DEFAULT_M);
      mode_act  <= 1'b0;
      m_pend    <= '0;
      mode_pend <= 1'b0;
      pend_v    <= 1'b0;
      cnt       <= '0;
      out_clk_r <= 1'b0;
      tick_r    <= 1'b0;
      div_err_r <= 1'b0;
    end else begin
      m_act     <= m_nxt;
      mode_act  <= mode_nxt;
      cnt       <= cnt_nxt;
      out_clk_r <= out_nxt;
      tick_r    <= tick_nxt;
      div_err_r <= accept & (div_m == '0);
      if (apply) begin
        pend_v <= 1'b0;
      end else if (accept && (div_m != '0)) begin
        m_pend    <= div_m;
        mode_pend <= div_mode;
        pend_v    <= 1'b1;
      end
    end
  end

  assign div_ready = ~pend_v;
  assign div_err   = div_err_r;
  assign tick      = tick_r;
  // Divide-by-one cannot be produced by a register, so the gated clock is passed through.
  assign out_clk   = (m_act == WIDTH'(1)) ? (clk & en & ~reset) : out_clk_r;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: period-position model plus directed scenarios.
module tb_clk_div_prog;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned DEFAULT_M = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic             div_valid = 1'b0;
  logic [WIDTH-1:0] div_m = '0;
  logic             div_mode = 1'b0;
  logic             div_ready, div_err, out_clk, tick;
  logic [WIDTH-1:0] cnt;

  clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_M(DEFAULT_M)) dut (
    .reset    (reset),
    .clk      (clk),
    .en       (en),
    .div_valid(div_valid),
    .div_m    (div_m),
    .div_mode (div_mode),
    .div_ready(div_ready),
    .div_err  (div_err),
    .out_clk  (out_clk),
    .tick     (tick),
    .cnt      (cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: position inside the current output period, active/pending settings,
  // and whether a period start has happened since reset or en was low.
  int md_m, md_mode, md_pm, md_pmode, md_pos;
  bit md_pv, md_fresh, md_err;

  task automatic model_reset();
    md_m = DEFAULT_M; md_mode = 0; md_pv = 0; md_pos = 0; md_fresh = 1; md_err = 0;
    md_pm = 0; md_pmode = 0;
  endtask

  task automatic model_apply();
    md_m = md_pm; md_mode = md_pmode; md_pv = 0;
  endtask

  task automatic model_step();
    bit had_pend;
    had_pend = md_pv;
    md_err = 0;
    if (!en) begin
      if (had_pend) model_apply();
      md_pos = 0;
      md_fresh = 1;
    end else begin
      if (md_pos == md_m - 1) begin
        if (had_pend) model_apply();
        md_pos = 0;
      end else begin
        md_pos = md_pos + 1;
      end
      md_fresh = 0;
    end
    if (div_valid && !had_pend) begin
      if (div_m == 0) md_err = 1;
      else begin
        md_pm = int'(div_m); md_pmode = int'(div_mode); md_pv = 1;
      end
    end
  endtask

  function automatic bit exp_tick();
    return (md_pos == 0) && !md_fresh;
  endfunction

  function automatic bit exp_out();
    if (md_m == 1) return clk && en && !reset;
    if (md_fresh) return 0;
    if (md_mode != 0) return md_pos < (md_m + 1) / 2;
    return md_pos == 0;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  task automatic compare_all(input string ph);
    check({"model_cnt_", ph}, cnt, md_pos);
    check({"model_tick_", ph}, tick, exp_tick());
    check({"model_out_clk_", ph}, out_clk, exp_out());
    check({"model_ready_", ph}, div_ready, !md_pv);
    check({"model_err_", ph}, div_err, md_err);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1; compare_all("hi");
      @(negedge clk); #1; compare_all("lo");
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_ready(input int bound, input string name);
    int k;
    k = 0;
    while (!div_ready && k < bound) begin
      step();
      k++;
    end
    check(name, div_ready, 1);
  endtask

  initial begin
    bit [0:3] p2;
    bit [0:9] p5_out, p5_tick;
    int k;

    p2      = 4'b0101;
    p5_out  = 10'b1110011100;
    p5_tick = 10'b1000010000;

    step();
    check("rst_cnt", cnt, 0);
    check("rst_out", out_clk, 0);
    check("rst_tick", tick, 0);
    check("rst_ready", div_ready, 1);
    check("rst_err", div_err, 0);

    reset = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("m2_out", out_clk, p2[i]);
      check("m2_tick", tick, p2[i]);
    end

    // M=5 near-50% requested at cnt=0; old period finishes first.
    check("pre_req_cnt", cnt, 0);
    div_valid = 1'b1; div_m = 8'd5; div_mode = 1'b1;
    step();
    div_valid = 1'b0;
    check("m5_held_ready", div_ready, 0);
    check("m5_old_cnt", cnt, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) check("m5_applied_ready", div_ready, 1);
      check("m5_out", out_clk, p5_out[i]);
      check("m5_tick", tick, p5_tick[i]);
    end

    // Rejected zero ratio.
    div_valid = 1'b1; div_m = '0; div_mode = 1'b0;
    step();
    div_valid = 1'b0;
    check("m0_err", div_err, 1);
    check("m0_ready", div_ready, 1);
    step();
    check("m0_err_clear", div_err, 0);

    // Back-to-back requests: second waits for the first to apply.
    div_valid = 1'b1; div_m = 8'd3; div_mode = 1'b0;
    step();
    div_m = 8'd4; div_mode = 1'b1;
    check("b2b_held", div_ready, 0);
    wait_ready(10, "b2b_first_apply");
    step();
    div_valid = 1'b0;
    check("b2b_second_accepted", div_ready, 0);
    wait_ready(10, "b2b_second_apply");
    k = 0;
    do begin
      step();
      k++;
    end while (!tick && k < 20);
    check("m4_period", k, 4);

    // Divide-by-one bypass.
    div_valid = 1'b1; div_m = 8'd1; div_mode = 1'b0;
    step();
    div_valid = 1'b0;
    wait_ready(10, "m1_apply");
    step(); step();
    check("m1_out_high", out_clk, 1);
    check("m1_tick", tick, 1);
    check("m1_cnt", cnt, 0);
    @(negedge clk); #1;
    check("m1_out_low", out_clk, 0);
    step();
    en = 1'b0;
    #1;
    check("m1_en_off_out", out_clk, 0);
    step();
    check("en_off_cnt", cnt, 0);
    check("en_off_tick", tick, 0);

    // Full-scale ratio, applied while disabled, then reset mid-period with a request pending.
    div_valid = 1'b1; div_m = 8'd255; div_mode = 1'b1;
    step();
    div_valid = 1'b0;
    check("m255_pending", div_ready, 0);
    step();
    check("m255_applied_en_off", div_ready, 1);
    en = 1'b1;
    k = 0;
    while (cnt != 8'd99 && k < 300) begin
      step();
      k++;
    end
    check("reach_cnt99", cnt, 99);
    div_valid = 1'b1; div_m = 8'd7; div_mode = 1'b0;
    step();
    div_valid = 1'b0;
    check("m255_cnt100", cnt, 100);
    check("m255_out_high", out_clk, 1);
    check("m255_req_pending", div_ready, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_cnt", cnt, 0);
    check("mid_rst_out", out_clk, 0);
    check("mid_rst_tick", tick, 0);
    check("mid_rst_ready", div_ready, 1);
    check("mid_rst_err", div_err, 0);
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_out", out_clk, p2[i]);
      check("post_rst_tick", tick, p2[i]);
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
